regfile: RTL and testbench
==========================

REGFILE -- requirements
Module: regfile

Interface
REQ-001 clk_i  input  1  Single core clock; all state updates on rising edge.
REQ-002 rst_i  input  1  Reset; asynchronous, active-low (`RstEnable = 1'b0).
REQ-003 we_i  input  1  Write enable from WB stage (`WriteEnable = 1).
REQ-004 waddr_i  input  5  Write register index (`RegAddrBus).
REQ-005 wdata_i  input  32  Write data (`RegBus).
REQ-006 reg1_re_i  input  1  Read-port-1 enable from ID (`ReadEnable = 1).
REQ-007 reg1_raddr_i  input  5  Read-port-1 index.
REQ-008 reg1_rdata_o  output  32  Read-port-1 data, combinational.
REQ-009 reg2_re_i  input  1  Read-port-2 enable from ID.
REQ-010 reg2_raddr_i  input  5  Read-port-2 index.
REQ-011 reg2_rdata_o  output  32  Read-port-2 data, combinational.
REQ-012 dbg_raddr_i  input  5  Debug/bench read index.
REQ-013 dbg_rdata_o  output  32  Debug read data, combinational, no bypass.

Function
REQ-014 Storage SHALL be 32 x 32-bit registers x0..x31; x0 SHALL always read 0.
REQ-015 Write SHALL occur at rising clk_i when rst_i high, we_i=1 and waddr_i!=0; array[waddr_i] <= wdata_i, visible in array from the following cycle.
REQ-016 Write with waddr_i=0 SHALL be discarded; no other register changes.
REQ-017 Read port N SHALL output 0 when rst_i low, or regN_re_i=0, or regN_raddr_i=0.
REQ-018 Else if we_i=1 and waddr_i==regN_raddr_i, port N SHALL output wdata_i in the same cycle (write-through bypass; closes the 3-instruction-apart hazard ID forwarding does not cover).
REQ-019 Else port N SHALL output array[regN_raddr_i].
REQ-020 Both read ports SHALL be independent; same index on both ports SHALL return identical data, including bypass case.
REQ-021 Read latency SHALL be zero cycles (pure combinational from address/enable/write inputs); write latency one edge.
REQ-022 dbg_rdata_o SHALL return array[dbg_raddr_i] (0 for index 0 and during reset) and SHALL NOT apply bypass.
REQ-023 Back-to-back writes to same index SHALL leave last-written value; no write merging or buffering.
REQ-024 No read-enable or write signal SHALL alter any register other than array[waddr_i].

Reset
REQ-025 rst_i falling SHALL clear all 32 registers to `ZeroWord immediately, independent of clk_i.
REQ-026 While rst_i low, all writes SHALL be ignored and all read outputs SHALL be 0.
REQ-027 Reset asserted mid-write (same cycle as we_i=1) SHALL win; register stays 0.
REQ-028 First write SHALL be accepted on the first rising edge after rst_i deasserts.

Structure
REQ-029 `RegBus, `RegAddrBus, `RegNum(32), `ZeroWord, `ZeroReg, `WriteEnable, `ReadEnable, `RstEnable SHALL come from the shared defines file; no local literals for these.
REQ-030 One sequential process for the array, one combinational process per read port; no sub-module (the read-port mux is small enough to instantiate twice inline).

Verification
REQ-031 Reset then read all 32 indices on both ports and debug -> all 0.
REQ-032 Write x5=0xDEADBEEF, next cycle reg1 read x5 re=1 -> 0xDEADBEEF; same read with re=0 -> 0.
REQ-033 Same cycle we=1 waddr=7 wdata=0x12345678, reg1/reg2 read x7, array x7=0x1 -> both ports 0x12345678, dbg x7=0x1; next cycle dbg=0x12345678.
REQ-034 Write x0=0xFFFFFFFF, read x0 same and next cycle with bypass condition -> 0.
REQ-035 Write x31=0xA5A5A5A5, assert rst_i low mid-cycle between edges -> dbg x31 reads 0 immediately, stays 0 after release.
REQ-036 Write x3=0x11 then x3=0x22 consecutive cycles, read x3 -> 0x22; x2 and x4 remain 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Register file shared types and constants.
// Widths, reset/enable polarities and the read-port mux helper.
package regfile_pkg;

    localparam int RegWidth     = 32;
    localparam int RegAddrWidth = 5;
    localparam int RegNum       = 32;

    typedef logic [RegWidth-1:0]     reg_t;
    typedef logic [RegAddrWidth-1:0] raddr_t;

    localparam reg_t   ZeroWord    = '0;
    localparam raddr_t ZeroReg     = '0;
    localparam logic   WriteEnable = 1'b1;
    localparam logic   ReadEnable  = 1'b1;
    localparam logic   RstEnable   = 1'b0;

    // Read-port value: zero on reset/disabled/x0,
    // then same-cycle write bypass, then stored value.
    function automatic reg_t rd_port(
        input logic   rst,
        input logic   re,
        input raddr_t ra,
        input logic   we,
        input raddr_t wa,
        input reg_t   wd,
        input reg_t   stored
    );
        reg_t v;
        v = ZeroWord;
        if (rst == RstEnable || re != ReadEnable || ra == ZeroReg) begin
            v = ZeroWord;
        end else if (we == WriteEnable && wa == ra) begin
            v = wd;
        end else begin
            v = stored;
        end
        return v;
    endfunction

endpackage

// File: rtl/regfile_if.sv
// Register file bus: one write port, two read ports, debug read.
// Signal names are seen from the register file side.
interface regfile_if;
    import regfile_pkg::*;

    logic   we_i;
    raddr_t waddr_i;
    reg_t   wdata_i;
    logic   reg1_re_i;
    raddr_t reg1_raddr_i;
    reg_t   reg1_rdata_o;
    logic   reg2_re_i;
    raddr_t reg2_raddr_i;
    reg_t   reg2_rdata_o;
    raddr_t dbg_raddr_i;
    reg_t   dbg_rdata_o;

    modport master (
        output we_i, waddr_i, wdata_i,
        output reg1_re_i, reg1_raddr_i,
        output reg2_re_i, reg2_raddr_i,
        output dbg_raddr_i,
        input  reg1_rdata_o, reg2_rdata_o,
        input  dbg_rdata_o
    );

    modport slave (
        input  we_i, waddr_i, wdata_i,
        input  reg1_re_i, reg1_raddr_i,
        input  reg2_re_i, reg2_raddr_i,
        input  dbg_raddr_i,
        output reg1_rdata_o, reg2_rdata_o,
        output dbg_rdata_o
    );

endinterface

// File: rtl/regfile.sv
// 32 x 32-bit integer register file, x0 hardwired to zero.
// Two bypassed combinational read ports plus an unbypassed debug port.
module regfile
    import regfile_pkg::*;
(
    input logic      clk_i,
    input logic      rst_i,
    regfile_if.slave rf
);

    reg_t regs_q [RegNum];
    logic wr_d;

    // A write lands only outside reset and never on x0.
    always_comb begin
        wr_d = (rf.we_i == WriteEnable) && (rf.waddr_i != ZeroReg);
    end

    // Storage: asynchronous clear, one write per rising edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (rst_i == RstEnable) begin
            for (int i = 0; i < RegNum; i++) begin
                regs_q[i] <= ZeroWord;
            end
        end else if (wr_d) begin
            regs_q[rf.waddr_i] <= rf.wdata_i;
        end
    end

    // Read port 1 with write-through bypass.
    always_comb begin
        rf.reg1_rdata_o = rd_port(
            rst_i, rf.reg1_re_i, rf.reg1_raddr_i,
            rf.we_i, rf.waddr_i, rf.wdata_i,
            regs_q[rf.reg1_raddr_i]);
    end

    // Read port 2 with write-through bypass.
    always_comb begin
        rf.reg2_rdata_o = rd_port(
            rst_i, rf.reg2_re_i, rf.reg2_raddr_i,
            rf.we_i, rf.waddr_i, rf.wdata_i,
            regs_q[rf.reg2_raddr_i]);
    end

    // Debug port shows stored contents only, no bypass.
    always_comb begin
        rf.dbg_rdata_o = ZeroWord;
        if (rst_i != RstEnable && rf.dbg_raddr_i != ZeroReg) begin
            rf.dbg_rdata_o = regs_q[rf.dbg_raddr_i];
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Register file bench: directed cases then random traffic
// compared against an array model of the architectural registers.
module tb_regfile;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_if rf ();

    regfile dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .rf    (rf)
    );

    logic [31:0] mem [32];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic re,
                                           input logic [4:0] a);
        if (!rst_n || !re || a == 5'd0) return 32'h0;
        if (rf.we_i && rf.waddr_i == a) return rf.wdata_i;
        return mem[a];
    endfunction

    function automatic logic [31:0] exp_dbg(input logic [4:0] a);
        if (!rst_n || a == 5'd0) return 32'h0;
        return mem[a];
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".r1"}, rf.reg1_rdata_o,
            exp_rd(rf.reg1_re_i, rf.reg1_raddr_i));
        chk({tag, ".r2"}, rf.reg2_rdata_o,
            exp_rd(rf.reg2_re_i, rf.reg2_raddr_i));
        chk({tag, ".dbg"}, rf.dbg_rdata_o,
            exp_dbg(rf.dbg_raddr_i));
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    endtask

    // Advance one clock: model takes the write at the edge,
    // return at the following falling edge.
    task automatic step();
        @(posedge clk);
        if (rst_n && rf.we_i && rf.waddr_i != 5'd0)
            mem[rf.waddr_i] = rf.wdata_i;
        @(negedge clk);
    endtask

    task automatic idle();
        rf.we_i         = 1'b0;
        rf.waddr_i      = '0;
        rf.wdata_i      = '0;
        rf.reg1_re_i    = 1'b0;
        rf.reg1_raddr_i = '0;
        rf.reg2_re_i    = 1'b0;
        rf.reg2_raddr_i = '0;
        rf.dbg_raddr_i  = '0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        rf.we_i    = 1'b1;
        rf.waddr_i = a;
        rf.wdata_i = d;
        step();
        rf.we_i = 1'b0;
    endtask

    task automatic rd_all(input logic [4:0] a);
        rf.reg1_re_i    = 1'b1;
        rf.reg1_raddr_i = a;
        rf.reg2_re_i    = 1'b1;
        rf.reg2_raddr_i = a;
        rf.dbg_raddr_i  = a;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // All registers read zero after reset
        for (int i = 0; i < 32; i++) begin
            rd_all(5'(i));
            #1;
            chk("rst.r1", rf.reg1_rdata_o, 32'h0);
            chk("rst.r2", rf.reg2_rdata_o, 32'h0);
            chk("rst.dbg", rf.dbg_rdata_o, 32'h0);
            step();
        end
        idle();

        // Plain write then read, enable gating
        wr(5'd5, 32'hDEADBEEF);
        rf.reg1_re_i    = 1'b1;
        rf.reg1_raddr_i = 5'd5;
        #1 chk("x5.re1", rf.reg1_rdata_o, 32'hDEADBEEF);
        rf.reg1_re_i = 1'b0;
        #1 chk("x5.re0", rf.reg1_rdata_o, 32'h0);
        idle();

        // Same-cycle bypass on both ports, debug unbypassed
        wr(5'd7, 32'h1);
        rf.we_i    = 1'b1;
        rf.waddr_i = 5'd7;
        rf.wdata_i = 32'h12345678;
        rd_all(5'd7);
        #1;
        chk("byp.r1", rf.reg1_rdata_o, 32'h12345678);
        chk("byp.r2", rf.reg2_rdata_o, 32'h12345678);
        chk("byp.dbg", rf.dbg_rdata_o, 32'h1);
        step();
        rf.we_i = 1'b0;
        #1 chk("byp.dbg1", rf.dbg_rdata_o, 32'h12345678);
        idle();

        // Writes to x0 discarded, no bypass
        rf.we_i    = 1'b1;
        rf.waddr_i = 5'd0;
        rf.wdata_i = 32'hFFFFFFFF;
        rd_all(5'd0);
        #1;
        chk("x0.r1", rf.reg1_rdata_o, 32'h0);
        chk("x0.r2", rf.reg2_rdata_o, 32'h0);
        step();
        #1;
        chk("x0.r1n", rf.reg1_rdata_o, 32'h0);
        chk("x0.dbg", rf.dbg_rdata_o, 32'h0);
        idle();

        // Back-to-back writes, neighbours untouched
        rf.we_i    = 1'b1;
        rf.waddr_i = 5'd3;
        rf.wdata_i = 32'h11;
        step();
        rf.wdata_i = 32'h22;
        step();
        rf.we_i = 1'b0;
        rd_all(5'd3);
        #1 chk("x3.r1", rf.reg1_rdata_o, 32'h22);
        rf.dbg_raddr_i = 5'd2;
        #1 chk("x2.dbg", rf.dbg_rdata_o, 32'h0);
        rf.dbg_raddr_i = 5'd4;
        #1 chk("x4.dbg", rf.dbg_rdata_o, 32'h0);
        idle();

        // Asynchronous reset mid-cycle, reset beats write
        wr(5'd31, 32'hA5A5A5A5);
        rd_all(5'd31);
        #1 chk("x31.pre", rf.dbg_rdata_o, 32'hA5A5A5A5);
        #1 rst_n = 1'b0;
        clear_model();
        #1;
        chk("x31.async", rf.dbg_rdata_o, 32'h0);
        chk("x31.r1rst", rf.reg1_rdata_o, 32'h0);
        rf.we_i    = 1'b1;
        rf.waddr_i = 5'd31;
        rf.wdata_i = 32'h1;
        step();
        #1;
        chk("rstwr.r1", rf.reg1_rdata_o, 32'h0);
        chk("rstwr.dbg", rf.dbg_rdata_o, 32'h0);
        rf.we_i = 1'b0;
        #1 rst_n = 1'b1;
        rf.we_i    = 1'b1;
        rf.waddr_i = 5'd9;
        rf.wdata_i = 32'h99;
        step();
        rf.we_i        = 1'b0;
        rf.dbg_raddr_i = 5'd9;
        #1 chk("first.x9", rf.dbg_rdata_o, 32'h99);
        rf.dbg_raddr_i = 5'd31;
        #1 chk("x31.post", rf.dbg_rdata_o, 32'h0);
        idle();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [4:0] hi;
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                clear_model();
            end else begin
                rst_n = 1'b1;
            end
            hi = ($urandom_range(0, 1) == 0) ? 5'd7 : 5'd31;
            rf.we_i         = 1'($urandom_range(0, 1));
            rf.waddr_i      = 5'($urandom_range(0, int'(hi)));
            rf.wdata_i      = $urandom;
            rf.reg1_re_i    = ($urandom_range(0, 4) != 0);
            rf.reg1_raddr_i = 5'($urandom_range(0, int'(hi)));
            rf.reg2_re_i    = ($urandom_range(0, 4) != 0);
            rf.reg2_raddr_i = 5'($urandom_range(0, int'(hi)));
            rf.dbg_raddr_i  = 5'($urandom_range(0, int'(hi)));
            if ($urandom_range(0, 3) == 0)
                rf.reg1_raddr_i = rf.waddr_i;
            if ($urandom_range(0, 3) == 0)
                rf.dbg_raddr_i = rf.waddr_i;
            #1 check_all("rnd");
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
